stream_write_arbiter: RTL and testbench
=======================================

Name: stream_write_arbiter

Overview:
Shares the single write port of a capture FIFO among NUM_SRC AXI-stream requesters. Arbitration is round-robin at packet granularity: once a source is granted, the grant is held until that source transfers a beat with tlast. The block sits directly upstream of the FIFO input, alongside its overflow monitor. It also reports the current grant and a forwarded-packet count for status registers.

Parameters:
NUM_SRC, 4, number of requesting sources; legal range 2..8.
DW, 512, data width of each stream in bits.
GW, $clog2(NUM_SRC), width of the grant index (derived; not overridden).

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
s_tvalid  in  NUM_SRC  per-source tvalid; bit i belongs to source i.
s_tdata  in  NUM_SRC*DW  per-source tdata; source i occupies bits [i*DW +: DW].
s_tlast  in  NUM_SRC  per-source end-of-packet flag.
s_tready  out  NUM_SRC  per-source tready.
m_tvalid  out  1  tvalid to the FIFO write port.
m_tdata  out  DW  tdata to the FIFO write port.
m_tlast  out  1  tlast to the FIFO write port.
m_tready  in  1  tready from the FIFO write port.
busy  out  1  high while a grant is held (state BUSY).
grant  out  GW  index of the granted source; valid while busy=1.
pkt_count  out  32  count of packets forwarded (tlast beats accepted on the master side).

Behaviour:
- State machine has two states, IDLE and BUSY. Only state, grant, last_grant and pkt_count are registered.
- Master outputs and s_tready are combinational from state and grant. There is no data register, so there is zero data latency in BUSY.
- Reset values (at the clock edge where reset=1):
  - state=IDLE, busy=0, grant=0, last_grant=NUM_SRC-1, pkt_count=0.
  - With reset=1, m_tvalid=0 and s_tready=0 on every bit.
- IDLE:
  - m_tvalid=0, m_tdata and m_tlast are don't-care, all s_tready=0.
  - If any s_tvalid bit is 1, select the first set bit scanning upward from (last_grant+1) mod NUM_SRC, wrapping around.
  - Load that index into grant and move to BUSY on the next edge.
  - Request-to-first-beat latency is therefore 1 cycle minimum.
  - If no s_tvalid bit is set, remain in IDLE.
- BUSY (granted index g):
  - m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], m_tlast=s_tlast[g].
  - s_tready[g]=m_tready; every other s_tready bit is 0.
  - A beat transfers when s_tvalid[g] & m_tready.
  - A transfer with s_tlast[g]=1 moves to IDLE on the next edge, sets last_grant<=g, and increments pkt_count.
  - Any other cycle stays in BUSY. This covers source stalls (tvalid low) and sink backpressure (m_tready low).
- After each packet there is one mandatory IDLE cycle (bubble) before the next grant.
- Grant is never revoked mid-packet, regardless of other requesters.
- tvalid on a non-granted source has no effect until the next IDLE arbitration. Its tready stays 0.
- Single-beat packets (tvalid and tlast on the first granted cycle) are legal: BUSY lasts 1 cycle if m_tready=1.
- pkt_count is modulo 2^32: 0xFFFFFFFF + 1 = 0.
- Reset mid-packet abandons the packet. State returns to IDLE, and no tready is asserted on the edge where reset is high.
- The block does not check the FIFO level. Backpressure comes only via m_tready.

Test Plan:
- Reset, then s_tvalid=4'b0001 with a 3-beat packet and m_tready=1 -> grant=0 one cycle after request, 3 beats pass in order, busy drops after the tlast beat, pkt_count=1.
- All four sources request continuously with 2-beat packets -> grant order 0,1,2,3,0; one IDLE bubble between packets; pkt_count=5 after 5 packets.
- Source 1 is granted, then source 0 asserts tvalid mid-packet -> s_tready[0] stays 0 and no source-0 data appears until the source-1 tlast; next grant is 2 if it is requesting, else 3, else 0.
- m_tready toggles 1,0,0,1 during a granted packet with tvalid held -> m_tvalid stays 1 and only the two m_tready=1 cycles transfer; s_tready[g] mirrors m_tready exactly.
- Assert reset for 1 cycle in the middle of a source-2 packet -> busy=0, s_tready=0 next cycle, pkt_count=0; the next arbitration starts the scan from source 0.
- Preload pkt_count to 0xFFFFFFFF via 2^32 packets (or a force), then send one more packet -> pkt_count=0.

Source files
------------

// File: rtl/stream_write_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-stream write port
// among NUM_SRC sources. Grant is held from the first beat to the tlast beat.
// Data, valid and ready pass through combinationally, so a beat crosses the
// arbiter in the same cycle. Exactly one idle cycle follows every packet.
module stream_write_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 512,
  localparam int GW     = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    s_tvalid,
  input  logic [NUM_SRC*DW-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]    s_tlast,
  output logic [NUM_SRC-1:0]    s_tready,
  output logic                  m_tvalid,
  output logic [DW-1:0]         m_tdata,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  busy,
  output logic [GW-1:0]         grant,
  output logic [31:0]           pkt_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [31:0]   pkt_count_q;
  logic          cnt_inc;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          xfer;

  // Per-source view of the flat data bus so the mux is a plain index.
  logic [NUM_SRC-1:0][DW-1:0] src_data;
  assign src_data = s_tdata;

  assign busy      = (state_q == BUSY);
  assign grant     = grant_q;
  assign pkt_count = pkt_count_q;

  // Master side mirrors the granted source; reset blanks valid immediately.
  assign m_tvalid = !reset && busy && s_tvalid[grant_q];
  assign m_tdata  = src_data[grant_q];
  assign m_tlast  = s_tlast[grant_q];
  assign xfer     = busy && s_tvalid[grant_q] && m_tready;

  // Only the granted source ever sees ready; it is a straight copy of the sink's.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_rdy
    assign s_tready[i] = !reset && busy && (grant_q == GW'(i)) && m_tready;
  end

  // Round-robin pick: first requester strictly after the last one served.
  always_comb begin
    logic [GW-1:0] idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = GW'((int'(last_q) + k) % NUM_SRC);
      if (!pick_found && s_tvalid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Next-state: arbitrate in IDLE, release the grant on the accepted tlast beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer && s_tlast[grant_q]) begin
          last_d  = grant_q;
          cnt_inc = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NUM_SRC - 1);
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      if (cnt_inc) pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_stream_write_arbiter.sv
// Bench for stream_write_arbiter: directed scenarios plus a random phase,
// all checked each cycle against a packet-level reference model.
module tb_stream_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int GW = $clog2(N);

  logic            clk, reset;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [N*DW-1:0] s_tdata;
  logic            m_tvalid, m_tlast, m_tready, busy;
  logic [DW-1:0]   m_tdata;
  logic [GW-1:0]   grant;
  logic [31:0]     pkt_count;

  stream_write_arbiter #(.NUM_SRC(N), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .grant(grant), .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the port (-1 = nobody), who was served last,
  // how many packets have completed.
  int          own  = -1;
  int          last = N - 1;
  logic [31:0] cnt  = '0;

  int n_cmp = 0;
  int n_err = 0;
  int glog[$];
  logic pb = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply inputs (just after a falling edge), then compare against the model.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic mr, input logic r);
    logic [N-1:0] er;
    logic         emv;
    s_tvalid = v; s_tlast = l; m_tready = mr; reset = r;
    for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = $urandom;
    #1;
    emv = !r && own >= 0 && v[own];
    er  = (!r && own >= 0 && mr) ? (N'(1) << own) : '0;
    chk("busy", busy, own >= 0);
    chk("m_tvalid", m_tvalid, emv);
    if (emv) begin
      chk("m_tdata", m_tdata, s_tdata[own*DW +: DW]);
      chk("m_tlast", m_tlast, l[own]);
    end
    chk("s_tready", s_tready, er);
    if (own >= 0) chk("grant", grant, own);
    chk("pkt_count", pkt_count, cnt);
    if (busy && !pb) glog.push_back(int'(grant));
    pb = busy;
  endtask

  // Clock edge: advance the model using the inputs that were on the bus.
  task automatic adv();
    bit found;
    int idx;
    @(posedge clk);
    if (reset) begin
      own = -1; last = N - 1; cnt = '0;
    end else if (own < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (last + k) % N;
        if (!found && s_tvalid[idx]) begin own = idx; found = 1; end
      end
    end else if (s_tvalid[own] && m_tready && s_tlast[own]) begin
      last = own; own = -1; cnt = cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l, input logic mr, input logic r);
    drive(v, l, mr, r);
    adv();
  endtask

  initial begin
    int bc[N];
    int o;
    int exp_order[5];
    logic [N-1:0] l;
    s_tvalid = '0; s_tlast = '0; m_tready = 1'b0; reset = 1'b1; s_tdata = '0;
    @(negedge clk);

    // 1: reset, then a 3-beat packet from source 0
    cyc('0, '0, 1'b1, 1'b1);
    cyc('0, '0, 1'b1, 1'b1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", pkt_count, 0);
    cyc(4'b0001, '0, 1'b1, 1'b0);
    chk("t1_grant", grant, 0);
    chk("t1_busy", busy, 1);
    cyc(4'b0001, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0001, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b1, 1'b0);
    chk("t1_busy_drop", busy, 0);
    chk("t1_cnt", pkt_count, 1);

    // 2: everyone requests 2-beat packets continuously
    cyc('0, '0, 1'b1, 1'b1);
    glog.delete();
    for (int i = 0; i < N; i++) bc[i] = 0;
    for (int t = 0; t < 200 && cnt != 5; t++) begin
      for (int i = 0; i < N; i++) l[i] = (bc[i] == 1);
      o = own;
      cyc(4'hF, l, 1'b1, 1'b0);
      if (o >= 0) bc[o] = (bc[o] == 1) ? 0 : bc[o] + 1;
    end
    chk("t2_cnt", pkt_count, 5);
    exp_order = '{0, 1, 2, 3, 0};
    chk("t2_ngrants", glog.size(), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++) chk("t2_order", glog[k], exp_order[k]);

    // 3: source 0 pokes in while source 1 holds the port
    cyc(4'b0010, '0, 1'b1, 1'b0);
    chk("t3_grant", grant, 1);
    drive(4'b0011, 4'b0000, 1'b1, 1'b0);
    chk("t3_rdy0_a", s_tready[0], 0);
    adv();
    drive(4'b0011, 4'b0010, 1'b1, 1'b0);
    chk("t3_rdy0_b", s_tready[0], 0);
    adv();
    cyc(4'b0101, '0, 1'b1, 1'b0);
    chk("t3_next", grant, 2);

    // 4: sink backpressure 1,0,0,1 on source 2's packet
    drive(4'b0100, 4'b0000, 1'b1, 1'b0);
    chk("t4_mv0", m_tvalid, 1); chk("t4_rdy0", s_tready, 4'b0100); adv();
    drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    chk("t4_mv1", m_tvalid, 1); chk("t4_rdy1", s_tready, 4'b0000); adv();
    drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    chk("t4_mv2", m_tvalid, 1); chk("t4_rdy2", s_tready, 4'b0000); adv();
    drive(4'b0100, 4'b0100, 1'b1, 1'b0);
    chk("t4_mv3", m_tvalid, 1); chk("t4_rdy3", s_tready, 4'b0100); adv();
    chk("t4_done", busy, 0);
    chk("t4_cnt", pkt_count, 7);

    // 5: reset in the middle of a source-2 packet
    cyc(4'b0100, '0, 1'b1, 1'b0);
    chk("t5_grant2", grant, 2);
    cyc(4'b0100, '0, 1'b1, 1'b0);
    drive(4'b0100, '0, 1'b1, 1'b1);
    chk("t5_rst_mv", m_tvalid, 0);
    chk("t5_rst_rdy", s_tready, 0);
    adv();
    drive(4'hF, '0, 1'b1, 1'b0);
    chk("t5_busy", busy, 0);
    chk("t5_rdy", s_tready, 0);
    chk("t5_cnt", pkt_count, 0);
    adv();
    chk("t5_grant0", grant, 0);
    cyc(4'hF, 4'b0001, 1'b1, 1'b0);

    // 6: counter wrap
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_count_q;
    cnt = 32'hFFFF_FFFF;
    cyc(4'b0001, 4'b0001, 1'b1, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b1, 1'b0);
    chk("t6_wrap", pkt_count, 0);

    // random traffic with occasional resets
    for (int t = 0; t < 3000; t++)
      cyc(N'($urandom), N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
